pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Parametrised next-generation program counter for the TinyChip fetch stage.
//   Adds to the PC: a runtime-loadable branch-target LUT, a call/return stack
//   (RAS), fetch stall, and sticky stack overflow/underflow flags.
//   Drives the instruction-memory word address. Instructions are word-indexed,
//   so sequential fetch increments the PC by 1.
// PARAMETERS
//   PC_W       9   PC / jump target width in bits
//   LUT_AW     5   branch LUT index width (2**LUT_AW entries of PC_W bits)
//   RAS_DEPTH  4   return-stack entries (power of 2, >=2)
// PORTS
//   clk          in   1          clock, rising edge
//   reset        in   1          asynchronous, active-high
//   stall        in   1          hold PC this cycle
//   jump         in   1          absolute jump to jump_target
//   jump_target  in   PC_W       jump/call destination
//   branch       in   1          taken branch through the LUT
//   branch_idx   in   LUT_AW     LUT entry selecting the branch destination
//   call         in   1          push pc+1, then go to jump_target
//   ret          in   1          pop the RAS into the PC
//   lut_we       in   1          write enable for the LUT
//   lut_waddr    in   LUT_AW     LUT write index
//   lut_wdata    in   PC_W       LUT write data
//   pc           out  PC_W       current fetch address (registered)
//   ras_ovf      out  1          sticky: a push occurred while the RAS was full
//   ras_unf      out  1          sticky: a pop occurred while the RAS was empty
// BEHAVIOUR
//   - Reset (async): pc=0, RAS pointer/count=0, ras_ovf=0, ras_unf=0.
//     LUT contents are not reset.
//   - Output timing: pc is a flop. A control asserted in cycle N is visible on
//     pc after edge N+1. There is no combinational path from inputs to pc.
//   - Next-PC priority, evaluated each edge:
//       stall > ret > call > jump > branch > pc+1
//     - stall: pc holds. No push or pop. LUT writes still take effect.
//     - ret, count>0: pc = top of stack; count--.
//     - ret, count==0: pc = pc+1; set ras_unf.
//     - call: push pc+1 (mod 2**PC_W); pc = jump_target.
//       If count==RAS_DEPTH, overwrite the oldest entry (circular), keep
//       count=RAS_DEPTH, and set ras_ovf.
//     - jump: pc = jump_target.
//     - branch: pc = lut[branch_idx].
//     - otherwise: pc = pc+1.
//   - Arithmetic is unsigned, modulo 2**PC_W; the all-ones PC wraps to 0.
//   - LUT: synchronous write, combinational read.
//     - Branch and write to the same index in the same cycle: the branch uses
//       the OLD entry. The write is visible from the next cycle.
//   - Lower-priority controls asserted alongside a winner are ignored with no
//     side effects. Example: call+ret performs the ret only; nothing is pushed.
//   - Flags stay set until reset.
//   - Reset mid-operation discards the stack. Stale RAS data is unobservable.
// STRUCTURE
//   - Package pc_pkg:
//     - typedef enum {PC_HOLD, PC_RET, PC_CALL, PC_JUMP, PC_BRANCH, PC_INC}
//       pc_sel_e
//     - localparam PC_RESET_VAL = '0
//   - Sub-module pc_ras (PC_W, RAS_DEPTH):
//     - ports: push, pop, push_data, top, empty, full
//     - circular buffer with wrap-on-full
//   - Top level: priority encoder to pc_sel_e, next-PC mux, LUT array, flags.
// TESTING
//   1. Reset, then 4 idle cycles -> pc = 0,1,2,3,4. Assert reset
//      asynchronously mid-cycle -> pc = 0 immediately.
//   2. Write lut[3]=9'h0A0, then branch idx 3 -> pc = 0x0A0.
//      Same-cycle write lut[3]=0x055 with branch idx 3 -> pc = 0x0A0.
//      Branch idx 3 again -> pc = 0x055.
//   3. At pc=0x010, call target 0x100, then 2 incs, then ret
//      -> pc = 0x100, 0x101, 0x102, 0x011.
//   4. 5 nested calls (RAS_DEPTH=4) -> ras_ovf=1. 4 rets return the 4 newest
//      pushes. A 5th ret -> pc+1 and ras_unf=1. Both flags stay set.
//   5. Assert stall+jump and stall+call -> pc holds, RAS count unchanged.
//      Release stall -> pc+1.
//   6. jump to 0x1FF, then idle -> pc = 0x000 (wrap).
//      Simultaneous ret+call+jump with an empty RAS -> pc+1, ras_unf=1,
//      no push.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the fetch-stage program counter
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_RET,
    PC_CALL,
    PC_JUMP,
    PC_BRANCH,
    PC_INC
  } pc_sel_e;

  localparam logic [31:0] PC_RESET_VAL = '0;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control, LUT write and PC/flag bundle of the fetch sequencer
interface pc_sequencer_if #(
  parameter int PC_W   = 9,
  parameter int LUT_AW = 5
);

  logic              stall;
  logic              jump;
  logic [PC_W-1:0]   jump_target;
  logic              branch;
  logic [LUT_AW-1:0] branch_idx;
  logic              call;
  logic              ret;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              ras_ovf;
  logic              ras_unf;

  modport master (
    output stall, jump, jump_target, branch, branch_idx, call, ret,
           lut_we, lut_waddr, lut_wdata,
    input  pc, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, jump, jump_target, branch, branch_idx, call, ret,
           lut_we, lut_waddr, lut_wdata,
    output pc, ras_ovf, ras_unf
  );

endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
  parameter int PC_W      = 9,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W:0]   count_q, count_d;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(RAS_DEPTH));
  assign top   = mem_q[wptr_q - PTR_W'(1)];

  // When full, wptr_q points at the oldest entry, so wrapping overwrites it.
  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PTR_W'(1);
      if (!full) begin
        count_d = count_q + (PTR_W+1)'(1);
      end
    end else if (pop && !empty) begin
      wptr_d  = wptr_q - PTR_W'(1);
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC with branch LUT, return stack, stall and sticky stack flags
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int LUT_AW    = 5,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.slave   bus
);

  localparam int LUT_N = 2 ** LUT_AW;

  pc_sel_e         sel;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic [PC_W-1:0] lut_q [LUT_N];
  logic [PC_W-1:0] ras_top;
  logic            ras_push, ras_pop, ras_empty, ras_full;

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    sel = PC_INC;
    if (bus.stall)       sel = PC_HOLD;
    else if (bus.ret)    sel = PC_RET;
    else if (bus.call)   sel = PC_CALL;
    else if (bus.jump)   sel = PC_JUMP;
    else if (bus.branch) sel = PC_BRANCH;
  end

  // LUT read happens before the same-edge write lands, so a branch sees the old entry.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    unique case (sel)
      PC_HOLD:   pc_d = pc_q;
      PC_RET: begin
        pc_d = ras_empty ? pc_inc : ras_top;
        if (ras_empty) unf_d = 1'b1;
      end
      PC_CALL: begin
        pc_d = bus.jump_target;
        if (ras_full) ovf_d = 1'b1;
      end
      PC_JUMP:   pc_d = bus.jump_target;
      PC_BRANCH: pc_d = lut_q[bus.branch_idx];
      default:   pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= PC_RESET_VAL[PC_W-1:0];
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.lut_we) begin
      lut_q[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  assign ras_push = (sel == PC_CALL);
  assign ras_pop  = (sel == PC_RET);

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign bus.pc      = pc_q;
  assign bus.ras_ovf = ovf_q;
  assign bus.ras_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  localparam int PC_W      = 9;
  localparam int LUT_AW    = 5;
  localparam int RAS_DEPTH = 4;

  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b100000;
  localparam logic [5:0] C_RET   = 6'b010000;
  localparam logic [5:0] C_CALL  = 6'b001000;
  localparam logic [5:0] C_JUMP  = 6'b000100;
  localparam logic [5:0] C_BR    = 6'b000010;
  localparam logic [5:0] C_WE    = 6'b000001;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            ovf;
    logic            unf;
  } exp_t;

  typedef struct {
    logic [5:0]        ctl;
    logic [PC_W-1:0]   tgt;
    logic [LUT_AW-1:0] idx;
    logic [LUT_AW-1:0] wa;
    logic [PC_W-1:0]   wd;
    exp_t              exp;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();

  pc_sequencer #(
    .PC_W      (PC_W),
    .LUT_AW    (LUT_AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  function automatic step_t mk(input logic [5:0] ctl, input logic [PC_W-1:0] tgt,
                               input logic [LUT_AW-1:0] idx, input logic [LUT_AW-1:0] wa,
                               input logic [PC_W-1:0] wd, input logic [PC_W-1:0] epc,
                               input logic eovf, input logic eunf);
    step_t s;
    s.ctl = ctl; s.tgt = tgt; s.idx = idx; s.wa = wa; s.wd = wd;
    s.exp = '{pc: epc, ovf: eovf, unf: eunf};
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.stall = 1'b0; bus.ret = 1'b0; bus.call = 1'b0; bus.jump = 1'b0;
    bus.branch = 1'b0; bus.lut_we = 1'b0; bus.jump_target = '0;
    bus.branch_idx = '0; bus.lut_waddr = '0; bus.lut_wdata = '0;
  endtask

  task automatic drive(input step_t s);
    bus.stall  = s.ctl[5];
    bus.ret    = s.ctl[4];
    bus.call   = s.ctl[3];
    bus.jump   = s.ctl[2];
    bus.branch = s.ctl[1];
    bus.lut_we = s.ctl[0];
    bus.jump_target = s.tgt;
    bus.branch_idx  = s.idx;
    bus.lut_waddr   = s.wa;
    bus.lut_wdata   = s.wd;
    sb_q.push_back(s.exp);
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step_t s[$];
    exp_t  e;
    set_idle();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus.pc, bus.ras_ovf, bus.ras_unf} !== {9'h000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got pc=%h ovf=%b unf=%b, need 000/0/0", bus.pc, bus.ras_ovf, bus.ras_unf);
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) s.push_back(mk(C_IDLE, 0, 0, 0, 0, 9'(i), 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if ({bus.pc, bus.ras_ovf, bus.ras_unf} !== e) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got pc=%h ovf=%b unf=%b, need pc=%h ovf=%b unf=%b",
                 i, bus.pc, bus.ras_ovf, bus.ras_unf, e.pc, e.ovf, e.unf);
      end
    end
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.pc !== 9'h000) begin
      n_err++;
      $display("FAIL async_reset: got pc=%h, need 000", bus.pc);
    end
    #1 reset = 1'b0;
    tick();
    n_cmp++;
    if (bus.pc !== 9'h001) begin
      n_err++;
      $display("FAIL after_async_reset: got pc=%h, need 001", bus.pc);
    end
  endtask

  task automatic test_lut_branch();
    step_t s[$];
    exp_t  e;
    do_reset();
    s.push_back(mk(C_WE,        0, 0, 3, 9'h0A0, 9'h001, 0, 0));
    s.push_back(mk(C_BR,        0, 3, 0, 0,      9'h0A0, 0, 0));
    s.push_back(mk(C_BR | C_WE, 0, 3, 3, 9'h055, 9'h0A0, 0, 0));
    s.push_back(mk(C_BR,        0, 3, 0, 0,      9'h055, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if ({bus.pc, bus.ras_ovf, bus.ras_unf} !== e) begin
        n_err++;
        $display("FAIL lut_branch[%0d]: got pc=%h ovf=%b unf=%b, need pc=%h ovf=%b unf=%b",
                 i, bus.pc, bus.ras_ovf, bus.ras_unf, e.pc, e.ovf, e.unf);
      end
    end
    set_idle();
  endtask

  task automatic test_call_ret();
    step_t s[$];
    exp_t  e;
    do_reset();
    s.push_back(mk(C_JUMP, 9'h010, 0, 0, 0, 9'h010, 0, 0));
    s.push_back(mk(C_CALL, 9'h100, 0, 0, 0, 9'h100, 0, 0));
    s.push_back(mk(C_IDLE, 0,      0, 0, 0, 9'h101, 0, 0));
    s.push_back(mk(C_IDLE, 0,      0, 0, 0, 9'h102, 0, 0));
    s.push_back(mk(C_RET,  0,      0, 0, 0, 9'h011, 0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if ({bus.pc, bus.ras_ovf, bus.ras_unf} !== e) begin
        n_err++;
        $display("FAIL call_ret[%0d]: got pc=%h ovf=%b unf=%b, need pc=%h ovf=%b unf=%b",
                 i, bus.pc, bus.ras_ovf, bus.ras_unf, e.pc, e.ovf, e.unf);
      end
    end
    set_idle();
  endtask

  task automatic test_ras_overflow();
    step_t s[$];
    exp_t  e;
    do_reset();
    s.push_back(mk(C_JUMP, 9'h010, 0, 0, 0, 9'h010, 0, 0));
    s.push_back(mk(C_CALL, 9'h020, 0, 0, 0, 9'h020, 0, 0));
    s.push_back(mk(C_CALL, 9'h040, 0, 0, 0, 9'h040, 0, 0));
    s.push_back(mk(C_CALL, 9'h060, 0, 0, 0, 9'h060, 0, 0));
    s.push_back(mk(C_CALL, 9'h080, 0, 0, 0, 9'h080, 0, 0));
    s.push_back(mk(C_CALL, 9'h0A0, 0, 0, 0, 9'h0A0, 1, 0));
    s.push_back(mk(C_RET,  0,      0, 0, 0, 9'h081, 1, 0));
    s.push_back(mk(C_RET,  0,      0, 0, 0, 9'h061, 1, 0));
    s.push_back(mk(C_RET,  0,      0, 0, 0, 9'h041, 1, 0));
    s.push_back(mk(C_RET,  0,      0, 0, 0, 9'h021, 1, 0));
    s.push_back(mk(C_RET,  0,      0, 0, 0, 9'h022, 1, 1));
    s.push_back(mk(C_IDLE, 0,      0, 0, 0, 9'h023, 1, 1));
    s.push_back(mk(C_IDLE, 0,      0, 0, 0, 9'h024, 1, 1));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if ({bus.pc, bus.ras_ovf, bus.ras_unf} !== e) begin
        n_err++;
        $display("FAIL ras_overflow[%0d]: got pc=%h ovf=%b unf=%b, need pc=%h ovf=%b unf=%b",
                 i, bus.pc, bus.ras_ovf, bus.ras_unf, e.pc, e.ovf, e.unf);
      end
    end
    set_idle();
  endtask

  task automatic test_stall();
    step_t s[$];
    exp_t  e;
    do_reset();
    s.push_back(mk(C_CALL,           9'h050, 0, 0, 0,      9'h050, 0, 0));
    s.push_back(mk(C_STALL | C_JUMP, 9'h123, 0, 0, 0,      9'h050, 0, 0));
    s.push_back(mk(C_STALL | C_CALL, 9'h1AA, 0, 0, 0,      9'h050, 0, 0));
    s.push_back(mk(C_STALL | C_RET,  0,      0, 0, 0,      9'h050, 0, 0));
    s.push_back(mk(C_STALL | C_WE,   0,      0, 7, 9'h133, 9'h050, 0, 0));
    s.push_back(mk(C_IDLE,           0,      0, 0, 0,      9'h051, 0, 0));
    s.push_back(mk(C_BR,             0,      7, 0, 0,      9'h133, 0, 0));
    s.push_back(mk(C_RET,            0,      0, 0, 0,      9'h001, 0, 0));
    s.push_back(mk(C_RET,            0,      0, 0, 0,      9'h002, 0, 1));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if ({bus.pc, bus.ras_ovf, bus.ras_unf} !== e) begin
        n_err++;
        $display("FAIL stall[%0d]: got pc=%h ovf=%b unf=%b, need pc=%h ovf=%b unf=%b",
                 i, bus.pc, bus.ras_ovf, bus.ras_unf, e.pc, e.ovf, e.unf);
      end
    end
    set_idle();
  endtask

  task automatic test_wrap_priority();
    step_t s[$];
    exp_t  e;
    do_reset();
    s.push_back(mk(C_JUMP,                  9'h1FF, 0, 0, 0, 9'h1FF, 0, 0));
    s.push_back(mk(C_IDLE,                  0,      0, 0, 0, 9'h000, 0, 0));
    s.push_back(mk(C_RET | C_CALL | C_JUMP, 9'h0F0, 0, 0, 0, 9'h001, 0, 1));
    s.push_back(mk(C_CALL,                  9'h0F0, 0, 0, 0, 9'h0F0, 0, 1));
    s.push_back(mk(C_RET | C_CALL,          9'h0AA, 0, 0, 0, 9'h002, 0, 1));
    s.push_back(mk(C_RET,                   0,      0, 0, 0, 9'h003, 0, 1));
    s.push_back(mk(C_JUMP | C_BR,           9'h1FF, 3, 0, 0, 9'h1FF, 0, 1));
    s.push_back(mk(C_CALL,                  9'h010, 0, 0, 0, 9'h010, 0, 1));
    s.push_back(mk(C_RET,                   0,      0, 0, 0, 9'h000, 0, 1));
    foreach (s[i]) begin
      drive(s[i]);
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if ({bus.pc, bus.ras_ovf, bus.ras_unf} !== e) begin
        n_err++;
        $display("FAIL wrap_priority[%0d]: got pc=%h ovf=%b unf=%b, need pc=%h ovf=%b unf=%b",
                 i, bus.pc, bus.ras_ovf, bus.ras_unf, e.pc, e.ovf, e.unf);
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_lut_branch();
    test_call_ret();
    test_ras_overflow();
    test_stall();
    test_wrap_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
